// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word/round sizes, schedule FSM encoding and the K round constants.
// The round datapath imports this package so both sides agree on a single K table.
package sha256_pkg;

    localparam int WORDSIZE = 32;
    localparam int ROUNDS   = 64;
    localparam int BLKBITS  = 512;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_e;

    localparam logic [WORDSIZE-1:0] K [0:ROUNDS-1] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [WORDSIZE-1:0] k_lookup(input logic [5:0] j);
        return K[j];
    endfunction

endpackage

// File: rtl/sha256_sched_sigma.sv
// Message-schedule small sigmas: sig0 = s0(a) = ROTR7^ROTR18^SHR3, sig1 = s1(b) = ROTR17^ROTR19^SHR10.
// Two independent inputs so one instance serves both taps of the schedule recurrence.
module sha256_sched_sigma
    import sha256_pkg::*;
(
    input  logic [WORDSIZE-1:0] a,
    input  logic [WORDSIZE-1:0] b,
    output logic [WORDSIZE-1:0] sig0,
    output logic [WORDSIZE-1:0] sig1
);

    assign sig0 = {a[6:0], a[31:7]} ^ {a[17:0], a[31:18]} ^ {3'b000, a[31:3]};
    assign sig1 = {b[16:0], b[31:17]} ^ {b[18:0], b[31:19]} ^ {10'd0, b[31:10]};

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule feeder: loads a 512-bit block into a 16-word window and streams
// W[j]/K[j] for j=0..63, one beat per handshake, with back-to-back block acceptance.
module sha256_msg_schedule
    import sha256_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                blk_valid,
    output logic                blk_ready,
    input  logic [BLKBITS-1:0]  blk_data,
    output logic                wk_valid,
    input  logic                wk_ready,
    output logic [WORDSIZE-1:0] Wj,
    output logic [WORDSIZE-1:0] Kj,
    output logic [5:0]          j_idx,
    output logic                wk_last,
    output logic                busy
);

    // Handshake: a transfer happens on a rising edge where valid && ready. Once wk_valid is
    // raised, Wj/Kj/j_idx/wk_last hold until that transfer; blk_ready never depends on blk_valid.

    sched_state_e        state;
    logic [5:0]          cnt;
    logic [WORDSIZE-1:0] window [16];
    logic [WORDSIZE-1:0] sig0;
    logic [WORDSIZE-1:0] sig1;
    logic [WORDSIZE-1:0] w_next;
    logic                run;
    logic                beat;
    logic                last_beat;
    logic                accept;

    assign run       = (state == ST_RUN);
    assign beat      = run && wk_ready;
    assign last_beat = beat && (cnt == 6'd63);
    assign blk_ready = !run || last_beat;
    assign accept    = blk_valid && blk_ready;

    sha256_sched_sigma u_sigma (
        .a    (window[1]),
        .b    (window[14]),
        .sig0 (sig0),
        .sig1 (sig1)
    );

    // Additions wrap at 32 bits; carries out of the word are intentionally dropped.
    assign w_next = sig1 + window[9] + sig0 + window[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            for (int i = 0; i < 16; i++) window[i] <= '0;
        end else if (accept) begin
            // Covers both the idle load and the load on the final beat of the previous block.
            state <= ST_RUN;
            cnt   <= '0;
            for (int i = 0; i < 16; i++) window[i] <= blk_data[BLKBITS-1-32*i -: 32];
        end else if (beat) begin
            for (int i = 0; i < 15; i++) window[i] <= window[i+1];
            window[15] <= w_next;
            cnt        <= cnt + 6'd1;
            if (cnt == 6'd63) state <= ST_IDLE;
        end
    end

    assign wk_valid = run;
    assign busy     = run;
    assign Wj       = run ? window[0] : '0;
    assign Kj       = run ? k_lookup(cnt) : '0;
    assign j_idx    = run ? cnt : '0;
    assign wk_last  = run && (cnt == 6'd63);

endmodule
